// File: rtl/encoder8_3_rr.sv
// Round-robin priority encoder: picks one of N requests fairly and presents its
// index on a registered valid/ready output, with a one-cycle one-hot grant pulse.
module encoder8_3_rr #(
  parameter int W = 3,
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic         out_multi,
  output logic [N-1:0] grant
);

  logic [W-1:0] r_ptr;
  logic         r_valid;
  logic [W-1:0] r_idx;
  logic         r_multi;
  logic [N-1:0] r_grant;

  logic         w_free;
  logic         w_load;
  logic         w_found;
  logic         w_multi;
  logic [W-1:0] w_k;
  logic [W-1:0] w_cand;

  assign w_free  = !r_valid || out_ready;
  assign w_multi = (req & (req - N'(1))) != '0;
  assign w_load  = w_free && en && w_found;

  // Scan from the farthest offset down so the one closest to r_ptr wins;
  // W-bit addition wraps modulo N because N == 2**W.
  always_comb begin
    w_k     = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_cand = r_ptr + W'(i);
      if (req[w_cand]) begin
        w_k     = w_cand;
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ptr   <= '0;
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_multi <= 1'b0;
      r_grant <= '0;
    end else begin
      r_grant <= '0;
      if (w_load) begin
        r_idx   <= w_k;
        r_valid <= 1'b1;
        r_multi <= w_multi;
        r_ptr   <= w_k + W'(1);
        r_grant <= N'(1) << w_k;
      end else if (w_free) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_idx   = r_idx;
  assign out_multi = r_multi;
  assign grant     = r_grant;

endmodule

// File: tb/tb_encoder8_3_rr.sv
// Directed-vector bench for encoder8_3_rr; each task checks its own scenario.
module tb_encoder8_3_rr;

  logic       clk;
  logic       reset;
  logic       en;
  logic [7:0] req;
  logic       out_ready;
  logic       out_valid;
  logic [2:0] out_idx;
  logic       out_multi;
  logic [7:0] grant;

  int checks;
  int failures;

  encoder8_3_rr #(.W(3), .N(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .req       (req),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_multi (out_multi),
    .grant     (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic v, input logic [2:0] idx,
                            input logic m, input logic [7:0] g);
    checks++;
    if (out_valid !== v || out_idx !== idx || out_multi !== m || grant !== g) begin
      failures++;
      $display("FAIL %s: got valid=%0b idx=%0d multi=%0b grant=%02h, want valid=%0b idx=%0d multi=%0b grant=%02h",
               name, out_valid, out_idx, out_multi, grant, v, idx, m, g);
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || grant !== 8'h00 || out_idx !== 3'd0) begin
        failures++;
        $display("FAIL reset_hold: got valid=%0b idx=%0d grant=%02h, want 0/0/00",
                 out_valid, out_idx, grant);
      end
    end
    reset = 1'b1;
    step();
    expect_out("reset_release", 1'b1, 3'd0, 1'b1, 8'h01);
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    en        = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req = 8'h01 << i;
      step();
      expect_out($sformatf("single_%0d", i), 1'b1, 3'(i), 1'b0, 8'h01 << i);
    end
    en  = 1'b0;
    req = 8'hFF;
    step();
    expect_out("en_low_0", 1'b0, 3'd7, 1'b0, 8'h00);
    step();
    expect_out("en_low_1", 1'b0, 3'd7, 1'b0, 8'h00);
  endtask

  task automatic test_rr_wrap();
    int cnt[8];
    for (int b = 0; b < 8; b++) cnt[b] = 0;
    en        = 1'b1;
    req       = 8'hFF;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      expect_out($sformatf("rr_%0d", c), 1'b1, 3'(c % 8), 1'b1, 8'h01 << (c % 8));
      if (c < 8)
        for (int b = 0; b < 8; b++) if (grant[b]) cnt[b]++;
    end
    for (int b = 0; b < 8; b++) begin
      checks++;
      if (cnt[b] != 1) begin
        failures++;
        $display("FAIL rr_fair_bit%0d: got %0d grants in 8 cycles, want 1", b, cnt[b]);
      end
    end
  endtask

  task automatic test_skip_wrap();
    req = 8'h20;
    step();
    expect_out("skip_setup", 1'b1, 3'd5, 1'b0, 8'h20);
    req = 8'b0000_0101;
    step();
    expect_out("skip_wrap0", 1'b1, 3'd0, 1'b1, 8'h01);
    step();
    expect_out("skip_next2", 1'b1, 3'd2, 1'b1, 8'h04);
  endtask

  task automatic test_backpressure();
    req = 8'h08;
    step();
    expect_out("bp_load3", 1'b1, 3'd3, 1'b0, 8'h08);
    out_ready = 1'b0;
    req       = 8'h80;
    for (int c = 0; c < 4; c++) begin
      step();
      expect_out($sformatf("bp_stall_%0d", c), 1'b1, 3'd3, 1'b0, 8'h00);
      if (c == 1) en = 1'b0;
      if (c == 2) en = 1'b1;
    end
    out_ready = 1'b1;
    step();
    expect_out("bp_release", 1'b1, 3'd7, 1'b0, 8'h80);
  endtask

  task automatic test_reset_mid();
    req = 8'h10;
    step();
    expect_out("rm_load4", 1'b1, 3'd4, 1'b0, 8'h10);
    out_ready = 1'b0;
    req       = 8'hFF;
    step();
    expect_out("rm_stall", 1'b1, 3'd4, 1'b0, 8'h00);
    reset = 1'b0;
    step();
    expect_out("rm_reset", 1'b0, 3'd0, 1'b0, 8'h00);
    reset     = 1'b1;
    out_ready = 1'b1;
    step();
    expect_out("rm_after", 1'b1, 3'd0, 1'b1, 8'h01);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    en        = 1'b1;
    req       = 8'hFF;
    out_ready = 1'b1;
    test_reset();
    test_single();
    test_rr_wrap();
    test_skip_wrap();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
